// File: rtl/ram_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ram_write_buffer
// Description : Posted-write FIFO between the data cache's RAM-side port and
//               port a of the dual-port data RAM. Writes are absorbed in one
//               cycle and drained to RAM in cycles the cache is not reading.
//               Pending entries forward read data, so the cache always sees
//               coherent data.
//
// Ports       : clk        - CPU clock (also clocks RAM port a)
//               reset      - synchronous, active-high reset
//               up_addr    - request address from the cache
//               up_wdata   - write data from the cache
//               up_write   - write request
//               up_read    - read request (a simultaneous write wins)
//               up_rdata   - read response, valid the cycle after acceptance,
//                            otherwise holds the last response
//               up_stall   - request not accepted this cycle, hold it
//               ram_addr   - RAM port a address
//               ram_wdata  - RAM port a write data
//               ram_wren   - RAM port a write enable
//               ram_q      - RAM port a registered read data (1-cycle latency)
//               wb_empty   - no pending writes
//               wb_count   - number of occupied entries
//
// Options     : WB_COALESCE_EN - when defined, a write hitting a pending entry
//               (other than the head being drained) updates it in place.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ram_write_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      up_addr,
    input  logic [DATA_WIDTH-1:0]      up_wdata,
    input  logic                       up_write,
    input  logic                       up_read,
    output logic [DATA_WIDTH-1:0]      up_rdata,
    output logic                       up_stall,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic [DATA_WIDTH-1:0]      ram_wdata,
    output logic                       ram_wren,
    input  logic [DATA_WIDTH-1:0]      ram_q,
    output logic                       wb_empty,
    output logic [$clog2(DEPTH):0]     wb_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

`ifdef WB_COALESCE_EN
    localparam bit c_COALESCE = 1'b1;
`else
    localparam bit c_COALESCE = 1'b0;
`endif

    // Registered state
    logic [ADDR_WIDTH-1:0] r_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_q [DEPTH];
    logic [c_PTR_W-1:0]    r_head_q, r_tail_q;
    logic [c_CNT_W-1:0]    r_count_q;
    logic                  r_rd_pend_q, r_rd_hit_q;
    logic [DATA_WIDTH-1:0] r_fwd_q, r_hold_q;

    // Next-state values
    logic [ADDR_WIDTH-1:0] w_addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] w_data_d [DEPTH];
    logic [c_PTR_W-1:0]    w_head_d, w_tail_d;
    logic [c_CNT_W-1:0]    w_count_d;
    logic                  w_rd_pend_d, w_rd_hit_d;
    logic [DATA_WIDTH-1:0] w_fwd_d, w_hold_d;

    // Lookup / control
    logic                  w_hit;
    logic [c_PTR_W-1:0]    w_match_idx;
    logic [c_PTR_W-1:0]    w_idx;
    logic [DATA_WIDTH-1:0] w_fwd;
    logic                  w_full, w_rd, w_rd_acc, w_coal, w_push, w_pop;

    // Associative lookup, scanned oldest to youngest so the last match (the
    // youngest) wins. Uses registered contents only, i.e. before this
    // cycle's pop, so forwarding from the entry being drained is valid.
    always_comb begin
        w_hit       = 1'b0;
        w_match_idx = '0;
        w_fwd       = '0;
        w_idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head_q + c_PTR_W'(k);
            if ((c_CNT_W'(k) < r_count_q) && (r_addr_q[w_idx] == up_addr)) begin
                w_hit       = 1'b1;
                w_match_idx = w_idx;
                w_fwd       = r_data_q[w_idx];
            end
        end
    end

    always_comb begin
        w_full   = (r_count_q == c_CNT_W'(DEPTH));
        w_rd     = up_read && !up_write;
        // A write cycle never carries a read, so a non-empty FIFO always
        // drains its head then; coalescing into the head is therefore never
        // allowed and a fresh entry is allocated instead.
        w_coal   = c_COALESCE && up_write && w_hit && (w_match_idx != r_head_q);
        up_stall = !reset && w_full && (up_write ? !w_coal : up_read);
        w_rd_acc = w_rd && !w_full && !reset;
        w_push   = up_write && !w_coal && !w_full && !reset;
        // Only a read miss needs the RAM port; any other cycle drains.
        w_pop    = (r_count_q != '0) && !(w_rd_acc && !w_hit) && !reset;
    end

    assign ram_addr  = (w_rd_acc && !w_hit) ? up_addr : r_addr_q[r_head_q];
    assign ram_wdata = r_data_q[r_head_q];
    assign ram_wren  = w_pop;
    assign up_rdata  = r_rd_pend_q ? (r_rd_hit_q ? r_fwd_q : ram_q) : r_hold_q;
    assign wb_empty  = (r_count_q == '0);
    assign wb_count  = r_count_q;

    always_comb begin
        w_addr_d    = r_addr_q;
        w_data_d    = r_data_q;
        w_head_d    = r_head_q;
        w_tail_d    = r_tail_q;
        w_count_d   = r_count_q;
        w_rd_pend_d = w_rd_acc;
        w_rd_hit_d  = w_hit;
        w_fwd_d     = w_fwd;
        w_hold_d    = up_rdata;

        if (w_coal && !reset) begin
            w_data_d[w_match_idx] = up_wdata;
        end
        if (w_push) begin
            w_addr_d[r_tail_q] = up_addr;
            w_data_d[r_tail_q] = up_wdata;
            w_tail_d           = r_tail_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            w_head_d = r_head_q + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
            2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_q    <= '0;
            r_tail_q    <= '0;
            r_count_q   <= '0;
            r_rd_pend_q <= 1'b0;
            r_rd_hit_q  <= 1'b0;
            r_fwd_q     <= '0;
            r_hold_q    <= '0;
        end else begin
            r_head_q    <= w_head_d;
            r_tail_q    <= w_tail_d;
            r_count_q   <= w_count_d;
            r_rd_pend_q <= w_rd_pend_d;
            r_rd_hit_q  <= w_rd_hit_d;
            r_fwd_q     <= w_fwd_d;
            r_hold_q    <= w_hold_d;
        end
    end

    // Entry storage carries no reset; contents are qualified by the count.
    always_ff @(posedge clk) begin
        r_addr_q <= w_addr_d;
        r_data_q <= w_data_d;
    end

endmodule
`default_nettype wire
